// File: rtl/fp_sum_pkg.sv
// Shared definitions for the fp_sum front-end: lane geometry, FP32 zero and the feeder FSM states.
package fp_sum_pkg;

   localparam int LANES = 16;
   localparam int FP_W = 32;
   localparam int CNT_W = 5;
   localparam int WAIT_W = 4;
   localparam logic [FP_W-1:0] FP_ZERO = 32'h0;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      OUT   = 2'd3
   } state_t;

endpackage

// File: rtl/fp_lane_buffer.sv
// 16x32 shadow register: one lane written per accepted word, all lanes cleared together.
module fp_lane_buffer
   import fp_sum_pkg::*;
(
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  wr_en,
   input  logic [3:0]            wr_idx,
   input  logic [FP_W-1:0]       wr_data,
   input  logic                  clr,
   output logic [LANES*FP_W-1:0] lane_data
);

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [FP_W-1:0] lane_reg;

         always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
               lane_reg <= FP_ZERO;
            end else if (clr) begin
               lane_reg <= FP_ZERO;
            end else if (wr_en && (wr_idx == 4'(gi))) begin
               lane_reg <= wr_data;
            end
         end

         assign lane_data[gi*FP_W +: FP_W] = lane_reg;
      end
   endgenerate

endmodule

// File: rtl/fp_sum_feeder.sv
// Packs FP32 operands into 16-lane groups for fp_sum_module, sequences accumulation
// across a packet, waits out the pipeline and returns one sum per packet.
module fp_sum_feeder
   import fp_sum_pkg::*;
#(
   parameter int LATENCY = 5
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [FP_W-1:0]       s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [LANES*FP_W-1:0] op_data,
   output logic                  op_en,
   output logic                  op_acc,
   input  logic [FP_W-1:0]       res_in,
   output logic [FP_W-1:0]       m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready
);

   state_t                  state_reg, state_next;
   logic [CNT_W-1:0]        cnt_reg;
   logic [WAIT_W-1:0]       wait_reg;
   logic                    grp_reg;
   logic                    last_reg;
   logic                    tready_reg, tready_next;
   logic                    op_en_reg, op_en_next;
   logic                    tvalid_reg, tvalid_next;
   logic                    op_acc_reg;
   logic [LANES*FP_W-1:0]   op_data_reg;
   logic [FP_W-1:0]         m_tdata_reg;
   logic [LANES*FP_W-1:0]   buf_data;
   logic [LANES*FP_W-1:0]   grp_data;
   logic                    accept;
   logic                    close_grp;
   logic                    wait_done;

   assign accept    = tready_reg && s_axis_tvalid;
   assign close_grp = accept && (s_axis_tlast || (cnt_reg == CNT_W'(LANES - 1)));
   assign wait_done = (state_reg == WAIT) && (wait_reg == WAIT_W'(LATENCY));

   fp_lane_buffer u_buf (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .wr_en     (accept),
      .wr_idx    (cnt_reg[3:0]),
      .wr_data   (s_axis_tdata),
      .clr       (state_reg == ISSUE),
      .lane_data (buf_data)
   );

   // The closing word is still in flight to the buffer, so merge it directly into the issued group.
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_merge
         assign grp_data[gi*FP_W +: FP_W] =
            (CNT_W'(gi) == cnt_reg) ? s_axis_tdata :
            (CNT_W'(gi) <  cnt_reg) ? buf_data[gi*FP_W +: FP_W] : FP_ZERO;
      end
   endgenerate

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_reg  <= FILL;
         tready_reg <= 1'b0;
         op_en_reg  <= 1'b0;
         tvalid_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         tready_reg <= tready_next;
         op_en_reg  <= op_en_next;
         tvalid_reg <= tvalid_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         FILL:    if (close_grp) state_next = ISSUE;
         ISSUE:   state_next = WAIT;
         WAIT:    if (wait_done) state_next = last_reg ? OUT : FILL;
         OUT:     if (m_axis_tready) state_next = FILL;
         default: state_next = FILL;
      endcase
   end

   // Outputs are registered, so they are decoded from the state being entered.
   always_comb begin
      tready_next = (state_next == FILL);
      op_en_next  = (state_next == ISSUE) || (state_next == WAIT);
      tvalid_next = (state_next == OUT);
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cnt_reg     <= '0;
         wait_reg    <= '0;
         grp_reg     <= 1'b0;
         last_reg    <= 1'b0;
         op_acc_reg  <= 1'b0;
         op_data_reg <= '0;
         m_tdata_reg <= FP_ZERO;
      end else begin
         if (accept) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
         if (close_grp) begin
            last_reg    <= s_axis_tlast;
            op_data_reg <= grp_data;
            op_acc_reg  <= grp_reg;
         end
         if (state_reg == ISSUE) begin
            cnt_reg  <= '0;
            grp_reg  <= 1'b1;
            wait_reg <= WAIT_W'(1);
         end else if (wait_done) begin
            wait_reg <= '0;
            if (last_reg) begin
               m_tdata_reg <= res_in;
               grp_reg     <= 1'b0;
            end
         end else if (state_reg == WAIT) begin
            wait_reg <= wait_reg + 1'b1;
         end
      end
   end

   assign s_axis_tready = tready_reg;
   assign op_en         = op_en_reg;
   assign op_acc        = op_acc_reg;
   assign op_data       = op_data_reg;
   assign m_axis_tdata  = m_tdata_reg;
   assign m_axis_tvalid = tvalid_reg;

endmodule

// File: tb/tb_fp_sum_feeder.sv
// Directed bench for fp_sum_feeder with a behavioural accumulating fp_sum_module model.
module tb_fp_sum_feeder;

   localparam int LAT = 5;

   logic         aclk = 1'b0;
   logic         aresetn = 1'b0;
   logic [31:0]  s_tdata = '0;
   logic         s_tvalid = 1'b0;
   logic         s_tready;
   logic         s_tlast = 1'b0;
   logic [511:0] op_data;
   logic         op_en;
   logic         op_acc;
   logic [31:0]  res_in;
   logic [31:0]  m_tdata;
   logic         m_tvalid;
   logic         m_tready = 1'b0;

   int checks = 0;
   int errors = 0;

   fp_sum_feeder #(.LATENCY(LAT)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tlast  (s_tlast),
      .op_data       (op_data),
      .op_en         (op_en),
      .op_acc        (op_acc),
      .res_in        (res_in),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready)
   );

   always #5 aclk = ~aclk;

   function automatic real fp32_to_real(input logic [31:0] b);
      logic [63:0] d;
      if (b[30:0] == 31'h0) return 0.0;
      d = {b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'h0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] real_to_fp32(input real r);
      logic [63:0] d;
      if (r == 0.0) return 32'h0;
      d = $realtobits(r);
      return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
   endfunction

   // fp_sum_module model: each enabled cycle pushes lane sum (+ current result when op_acc).
   real pipe [LAT];
   always @(posedge aclk or negedge aresetn) begin : model
      real s;
      if (!aresetn) begin
         for (int i = 0; i < LAT; i++) pipe[i] <= 0.0;
      end else if (op_en) begin
         s = 0.0;
         for (int i = 0; i < 16; i++) s = s + fp32_to_real(op_data[i*32 +: 32]);
         if (op_acc) s = s + pipe[LAT-1];
         for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
         pipe[0] <= s;
      end
   end
   always_comb res_in = real_to_fp32(pipe[LAT-1]);

   // op_en burst monitor
   int           nb = 0;
   logic [511:0] b_data [16];
   logic         b_acc [16];
   int           b_len [16];
   logic         prev_en = 1'b0;
   always @(negedge aclk) begin
      if (op_en && nb <= 16) begin
         if (!prev_en && nb < 16) begin
            b_data[nb] = op_data;
            b_acc[nb]  = op_acc;
            b_len[nb]  = 0;
            nb = nb + 1;
         end
         if (nb > 0) b_len[nb-1] = b_len[nb-1] + 1;
      end
      prev_en = op_en;
   end

   logic [31:0] fp_int [17];
   initial begin
      fp_int[0]  = 32'h00000000; fp_int[1]  = 32'h3f800000; fp_int[2]  = 32'h40000000;
      fp_int[3]  = 32'h40400000; fp_int[4]  = 32'h40800000; fp_int[5]  = 32'h40a00000;
      fp_int[6]  = 32'h40c00000; fp_int[7]  = 32'h40e00000; fp_int[8]  = 32'h41000000;
      fp_int[9]  = 32'h41100000; fp_int[10] = 32'h41200000; fp_int[11] = 32'h41300000;
      fp_int[12] = 32'h41400000; fp_int[13] = 32'h41500000; fp_int[14] = 32'h41600000;
      fp_int[15] = 32'h41700000; fp_int[16] = 32'h41800000;
   end

   // Starts and ends on a falling edge.
   task automatic send_word(input logic [31:0] d, input logic l);
      int k;
      s_tdata = d;
      s_tlast = l;
      s_tvalid = 1'b1;
      for (k = 0; k < 200 && !s_tready; k++) @(negedge aclk);
      if (!s_tready) begin
         checks++; errors++;
         $display("FAIL send_word timeout: s_axis_tready=%0b required 1", s_tready);
      end
      @(posedge aclk);
      @(negedge aclk);
      s_tvalid = 1'b0;
      s_tlast = 1'b0;
   endtask

   task automatic get_result(output logic [31:0] d, output int n);
      m_tready = 1'b1;
      n = 0;
      while (!m_tvalid && n < 200) begin
         @(negedge aclk);
         n++;
      end
      if (!m_tvalid) begin
         checks++; errors++;
         $display("FAIL get_result timeout: m_axis_tvalid=%0b required 1", m_tvalid);
      end
      d = m_tdata;
      @(posedge aclk);
      @(negedge aclk);
      m_tready = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({s_tready, op_en, op_acc, m_tvalid} !== 4'b0000 || op_data !== '0 || m_tdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: tready=%0b en=%0b acc=%0b tvalid=%0b tdata=%h required all 0",
                  s_tready, op_en, op_acc, m_tvalid, m_tdata);
      end
      @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      checks++;
      if (s_tready !== 1'b1) begin
         errors++;
         $display("FAIL reset_tready: s_axis_tready=%0b required 1", s_tready);
      end
      $display("test_reset done");
   endtask

   task automatic test_full_group();
      int base, n;
      logic [31:0] r;
      base = nb;
      for (int i = 1; i <= 16; i++) send_word(fp_int[i], i == 16);
      get_result(r, n);
      checks++;
      if (nb - base !== 1) begin
         errors++; $display("FAIL full_bursts: got %0d required 1", nb - base);
      end
      checks++;
      if (b_len[base] !== LAT + 1) begin
         errors++; $display("FAIL full_en_len: got %0d required %0d", b_len[base], LAT + 1);
      end
      checks++;
      if (b_acc[base] !== 1'b0) begin
         errors++; $display("FAIL full_acc: got %0b required 0", b_acc[base]);
      end
      checks++;
      if (b_data[base][31:0] !== 32'h3f800000 || b_data[base][511:480] !== 32'h41800000) begin
         errors++;
         $display("FAIL full_lanes: lane0=%h lane15=%h required 3f800000 41800000",
                  b_data[base][31:0], b_data[base][511:480]);
      end
      checks++;
      if (n !== LAT + 1) begin
         errors++; $display("FAIL full_latency: tvalid after %0d cycles required %0d", n, LAT + 1);
      end
      checks++;
      if (r !== 32'h43080000) begin
         errors++; $display("FAIL full_sum: got %h required 43080000", r);
      end
      $display("test_full_group sum=%h latency=%0d", r, n);
   endtask

   task automatic test_multi_group();
      int base, n;
      logic [31:0] r;
      logic [511:0] exp2;
      base = nb;
      for (int i = 1; i <= 20; i++) send_word(32'h3f800000, i == 20);
      get_result(r, n);
      exp2 = '0;
      for (int i = 0; i < 4; i++) exp2[i*32 +: 32] = 32'h3f800000;
      checks++;
      if (nb - base !== 2) begin
         errors++; $display("FAIL multi_bursts: got %0d required 2", nb - base);
      end
      checks++;
      if (b_acc[base] !== 1'b0 || b_acc[base+1] !== 1'b1) begin
         errors++; $display("FAIL multi_acc: got %0b,%0b required 0,1", b_acc[base], b_acc[base+1]);
      end
      checks++;
      if (b_data[base+1] !== exp2) begin
         errors++; $display("FAIL multi_lanes2: got %h required %h", b_data[base+1], exp2);
      end
      checks++;
      if (r !== 32'h41a00000) begin
         errors++; $display("FAIL multi_sum: got %h required 41a00000", r);
      end
      $display("test_multi_group sum=%h", r);
   endtask

   task automatic test_single_word();
      int base, n;
      logic [31:0] r;
      base = nb;
      send_word(32'h40200000, 1'b1);
      get_result(r, n);
      checks++;
      if (b_data[base] !== {480'h0, 32'h40200000}) begin
         errors++; $display("FAIL single_lanes: got %h required lane0=40200000 others 0", b_data[base]);
      end
      checks++;
      if (r !== 32'h40200000) begin
         errors++; $display("FAIL single_sum: got %h required 40200000", r);
      end
      $display("test_single_word sum=%h", r);
   endtask

   task automatic test_backpressure();
      int k, n;
      logic [31:0] held, r;
      send_word(32'h3f800000, 1'b1);
      for (k = 0; k < 200 && !m_tvalid; k++) @(negedge aclk);
      held = m_tdata;
      checks++;
      if (m_tvalid !== 1'b1 || held !== 32'h3f800000) begin
         errors++; $display("FAIL bp_result: tvalid=%0b tdata=%h required 1 3f800000", m_tvalid, held);
      end
      s_tdata = 32'h40400000; s_tlast = 1'b1; s_tvalid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge aclk);
         checks++;
         if (m_tvalid !== 1'b1 || m_tdata !== held || s_tready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d: tvalid=%0b tdata=%h tready=%0b required 1 %h 0",
                     c, m_tvalid, m_tdata, s_tready, held);
         end
      end
      m_tready = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      m_tready = 1'b0;
      checks++;
      if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
         errors++; $display("FAIL bp_release: tvalid=%0b tready=%0b required 0 1", m_tvalid, s_tready);
      end
      send_word(32'h40400000, 1'b1);
      get_result(r, n);
      checks++;
      if (r !== 32'h40400000) begin
         errors++; $display("FAIL bp_next_sum: got %h required 40400000", r);
      end
      $display("test_backpressure held=%h next=%h", held, r);
   endtask

   task automatic test_reset_in_wait();
      int base, n;
      logic [31:0] r;
      for (int i = 1; i <= 16; i++) send_word(fp_int[i], i == 16);
      repeat (3) @(negedge aclk);
      aresetn = 1'b0;
      #1;
      checks++;
      if ({s_tready, op_en, op_acc, m_tvalid} !== 4'b0000 || op_data !== '0 || m_tdata !== 32'h0) begin
         errors++;
         $display("FAIL rst_wait_outputs: tready=%0b en=%0b acc=%0b tvalid=%0b data_nonzero=%0b required all 0",
                  s_tready, op_en, op_acc, m_tvalid, op_data != '0);
      end
      @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      base = nb;
      for (int i = 1; i <= 16; i++) send_word(fp_int[i], i == 16);
      get_result(r, n);
      checks++;
      if (b_acc[base] !== 1'b0) begin
         errors++; $display("FAIL rst_wait_acc: got %0b required 0", b_acc[base]);
      end
      checks++;
      if (r !== 32'h43080000) begin
         errors++; $display("FAIL rst_wait_sum: got %h required 43080000", r);
      end
      $display("test_reset_in_wait sum=%h", r);
   endtask

   initial begin
      test_reset();
      test_full_group();
      test_multi_group();
      test_single_word();
      test_backpressure();
      test_reset_in_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
